// File: rtl/microcode_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : microcode_loader_pkg
//  Description : Shared types and constants for the microcode bootstrap
//                loader: loader state encoding, checksum width and byte
//                stream handshake helpers reusable by any byte source.
//  Revision    : 1.0 - initial release
// ============================================================================
package microcode_loader_pkg;

    // Byte stream shared by all bootstrap byte sources (serial, ROM, ...)
    localparam int STREAM_DATA_WIDTH = 8;
    localparam int CHECKSUM_WIDTH    = 8;

    // Top-level loader states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_RECOVER   = 3'd4,
        ST_CHECK     = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } loader_state_e;

    // A byte moves on any cycle where both sides of the handshake agree
    function automatic logic stream_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

    // Two's-complement checksum: running sum plus checksum byte wraps to zero
    function automatic logic checksum_ok(input logic [CHECKSUM_WIDTH-1:0] sum,
                                         input logic [CHECKSUM_WIDTH-1:0] chk);
        logic [CHECKSUM_WIDTH-1:0] total;
        total = sum + chk;
        return (total == '0);
    endfunction

endpackage : microcode_loader_pkg
`default_nettype wire

// File: rtl/microcode_loader_write_strober.sv
`default_nettype none
// ============================================================================
//  Module      : microcode_loader_write_strober
//  Description : Generates one SRAM write cycle per start request:
//                SETUP (addr/data stable) -> STROBE (n_we low) -> RECOVER
//                (n_we high, addr/data still held). Owns the address and
//                data hold registers and the active-low write strobe.
//  Ports       : clk_i, rst_i   - clock, asynchronous active-high reset
//                clear_i        - rewind address to 0 (honoured when idle)
//                start_i/data_i - begin a write of data_i at the current addr
//                addr_o/data_o  - SRAM address and write data (registered)
//                n_we_o         - SRAM write strobe, active-low (registered)
//                done_o         - high during RECOVER, the last write cycle
//                last_o         - current address is the final byte address
//  Revision    : 1.0 - initial release
// ============================================================================
module microcode_loader_write_strober
    import microcode_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LENGTH     = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [STREAM_DATA_WIDTH-1:0] data_i,
    output logic [ADDR_WIDTH-1:0]        addr_o,
    output logic [STREAM_DATA_WIDTH-1:0] data_o,
    output logic                         n_we_o,
    output logic                         done_o,
    output logic                         last_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);

    localparam logic [1:0] PH_IDLE    = 2'd0;
    localparam logic [1:0] PH_SETUP   = 2'd1;
    localparam logic [1:0] PH_STROBE  = 2'd2;
    localparam logic [1:0] PH_RECOVER = 2'd3;

    logic [1:0]                   phase_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [STREAM_DATA_WIDTH-1:0] data_q;
    logic                         n_we_q;

    // The strobe register is on the asynchronous reset, so a reset landing
    // mid-STROBE releases the SRAM write immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= PH_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            n_we_q  <= 1'b1;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    if (clear_i) begin
                        addr_q <= '0;
                    end
                    if (start_i) begin
                        data_q  <= data_i;
                        phase_q <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    n_we_q  <= 1'b0;
                    phase_q <= PH_STROBE;
                end
                PH_STROBE: begin
                    n_we_q  <= 1'b1;
                    phase_q <= PH_RECOVER;
                end
                PH_RECOVER: begin
                    // Address saturates at the final byte so it can never wrap
                    if (addr_q != LAST_ADDR) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                    end
                    phase_q <= PH_IDLE;
                end
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

    assign addr_o = addr_q;
    assign data_o = data_q;
    assign n_we_o = n_we_q;
    assign done_o = (phase_q == PH_RECOVER);
    assign last_o = (addr_q == LAST_ADDR);

`ifdef FORMAL
    // Address and data must not move on either edge of the strobe
    a_hold_around_we: assert property (@(posedge clk_i) disable iff (rst_i)
        (n_we_q != $past(n_we_q)) |-> ($stable(addr_q) && $stable(data_q)));
    a_addr_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        addr_q <= LAST_ADDR);
`endif

endmodule : microcode_loader_write_strober
`default_nettype wire

// File: rtl/microcode_loader.sv
`default_nettype none
// ============================================================================
//  Module      : microcode_loader
//  Description : Loads microcode bytes from a valid/ready stream into the
//                microcode SRAM bootstrap port, verifies the trailing
//                two's-complement checksum, then releases the SRAM
//                (N_BOOTED low) and the core reset.
//  Ports       : CLK, RST           - clock, asynchronous active-high reset
//                START              - begin a load from IDLE or ERROR
//                IN_DATA/IN_VALID   - stream byte and its valid
//                IN_READY           - loader accepts a byte this cycle
//                BOOTSTRAP_ADDR/DATA- SRAM byte address and write data
//                BOOTSTRAP_N_WE     - SRAM write strobe, active-low
//                N_BOOTED           - high until a verified load completes
//                CORE_RST           - holds the core in reset until booted
//                LOAD_ERR           - checksum mismatch detected
//  Revision    : 1.0 - initial release
// ============================================================================
module microcode_loader
    import microcode_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LENGTH     = 4096
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic [STREAM_DATA_WIDTH-1:0] IN_DATA,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [ADDR_WIDTH-1:0]        BOOTSTRAP_ADDR,
    output logic [STREAM_DATA_WIDTH-1:0] BOOTSTRAP_DATA,
    output logic                         BOOTSTRAP_N_WE,
    output logic                         N_BOOTED,
    output logic                         CORE_RST,
    output logic                         LOAD_ERR
);

    loader_state_e               state_q;
    logic                        in_ready_q;
    logic                        n_booted_q;
    logic                        core_rst_q;
    logic                        load_err_q;
    logic [CHECKSUM_WIDTH-1:0]   sum_q;

    logic w_fire;
    logic w_launch;
    logic w_rewind;
    logic w_wr_done;
    logic w_wr_last;

    // in_ready_q is only ever high in WAIT_BYTE or CHECK, so a fire outside
    // those states cannot happen.
    assign w_fire   = stream_fire(IN_VALID, in_ready_q);
    assign w_launch = w_fire && (state_q == ST_WAIT_BYTE);
    assign w_rewind = START && ((state_q == ST_IDLE) || (state_q == ST_ERROR));

    microcode_loader_write_strober #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LENGTH     (LENGTH)
    ) u_write_strober (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clear_i (w_rewind),
        .start_i (w_launch),
        .data_i  (IN_DATA),
        .addr_o  (BOOTSTRAP_ADDR),
        .data_o  (BOOTSTRAP_DATA),
        .n_we_o  (BOOTSTRAP_N_WE),
        .done_o  (w_wr_done),
        .last_o  (w_wr_last)
    );

    // SETUP/STROBE/RECOVER advance in lockstep with the strober so the
    // loader state always names the current write phase.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            n_booted_q <= 1'b1;
            core_rst_q <= 1'b1;
            load_err_q <= 1'b0;
            sum_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (START) begin
                        state_q    <= ST_WAIT_BYTE;
                        in_ready_q <= 1'b1;
                        sum_q      <= '0;
                        load_err_q <= 1'b0;
                    end
                end
                ST_WAIT_BYTE: begin
                    if (w_fire) begin
                        sum_q      <= sum_q + IN_DATA;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP:  state_q <= ST_STROBE;
                ST_STROBE: state_q <= ST_RECOVER;
                ST_RECOVER: begin
                    if (w_wr_done) begin
                        state_q    <= w_wr_last ? ST_CHECK : ST_WAIT_BYTE;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    // The checksum byte is consumed here and never written
                    if (w_fire) begin
                        in_ready_q <= 1'b0;
                        if (checksum_ok(sum_q, IN_DATA)) begin
                            state_q    <= ST_DONE;
                            n_booted_q <= 1'b0;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q    <= ST_ERROR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Terminal until reset
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign IN_READY = in_ready_q;
    assign N_BOOTED = n_booted_q;
    assign CORE_RST = core_rst_q;
    assign LOAD_ERR = load_err_q;

`ifdef FORMAL
    a_we_only_in_strobe: assert property (@(posedge CLK) disable iff (RST)
        !BOOTSTRAP_N_WE |-> (state_q == ST_STROBE));
    a_no_we_when_booted: assert property (@(posedge CLK) disable iff (RST)
        !N_BOOTED |-> BOOTSTRAP_N_WE);
    a_addr_hold_on_we: assert property (@(posedge CLK) disable iff (RST)
        (BOOTSTRAP_N_WE != $past(BOOTSTRAP_N_WE)) |->
            ($stable(BOOTSTRAP_ADDR) && $stable(BOOTSTRAP_DATA)));
`endif

endmodule : microcode_loader
`default_nettype wire

// File: tb/tb_microcode_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_microcode_loader
//  Description : Scoreboard bench for microcode_loader. Stimulus pushes the
//                expected SRAM writes into a queue; a negedge monitor pops
//                and compares on every write strobe. Two instances cover
//                LENGTH=4 and LENGTH=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_microcode_loader;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LENGTH=4
    logic        a_start, a_valid, a_ready, a_nwe, a_nbooted, a_corerst, a_err;
    logic [7:0]  a_data, a_bdata;
    logic [11:0] a_addr;
    // Instance B: LENGTH=1
    logic        b_start, b_valid, b_ready, b_nwe, b_nbooted, b_corerst, b_err;
    logic [7:0]  b_data, b_bdata;
    logic [11:0] b_addr;

    microcode_loader #(.ADDR_WIDTH(12), .LENGTH(4)) u_dut_a (
        .CLK(clk), .RST(rst), .START(a_start), .IN_DATA(a_data),
        .IN_VALID(a_valid), .IN_READY(a_ready), .BOOTSTRAP_ADDR(a_addr),
        .BOOTSTRAP_DATA(a_bdata), .BOOTSTRAP_N_WE(a_nwe),
        .N_BOOTED(a_nbooted), .CORE_RST(a_corerst), .LOAD_ERR(a_err)
    );

    microcode_loader #(.ADDR_WIDTH(12), .LENGTH(1)) u_dut_b (
        .CLK(clk), .RST(rst), .START(b_start), .IN_DATA(b_data),
        .IN_VALID(b_valid), .IN_READY(b_ready), .BOOTSTRAP_ADDR(b_addr),
        .BOOTSTRAP_DATA(b_bdata), .BOOTSTRAP_N_WE(b_nwe),
        .N_BOOTED(b_nbooted), .CORE_RST(b_corerst), .LOAD_ERR(b_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] q_a[$];
    logic [19:0] q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    // ---------------- monitors: one write per strobe, strobe one cycle wide
    int a_low = 0;
    always @(negedge clk) begin
        if (rst) a_low = 0;
        else if (!a_nwe) begin
            a_low++;
            if (a_low == 1) begin
                if (q_a.size() == 0) check("A_spurious_write", 32'(q_a.size()), 32'(1));
                else check("A_write", 32'({a_addr, a_bdata}), 32'(q_a.pop_front()));
                check("A_we_while_booted", 32'(a_nbooted), 32'(1));
            end
        end else begin
            if (a_low != 0) check("A_we_width", 32'(a_low), 32'(1));
            a_low = 0;
        end
    end

    int b_low = 0;
    always @(negedge clk) begin
        if (rst) b_low = 0;
        else if (!b_nwe) begin
            b_low++;
            if (b_low == 1) begin
                if (q_b.size() == 0) check("B_spurious_write", 32'(q_b.size()), 32'(1));
                else check("B_write", 32'({b_addr, b_bdata}), 32'(q_b.pop_front()));
                check("B_we_while_booted", 32'(b_nbooted), 32'(1));
            end
        end else begin
            if (b_low != 0) check("B_we_width", 32'(b_low), 32'(1));
            b_low = 0;
        end
    end

    // ---------------- stimulus helpers (all return at posedge + 1)
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        @(posedge clk);
        #1;
        if (sel) b_start = 1'b0; else a_start = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [7:0] d);
        int n = 0;
        if (sel) begin b_valid = 1'b1; b_data = d; end
        else begin a_valid = 1'b1; a_data = d; end
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? b_ready : a_ready) && n < 100);
        if (n >= 100) begin
            n_checks++;
            $display("FAIL send_timeout: actual=no_ready expected=ready sel=%0d", sel);
        end
        @(posedge clk);
        #1;
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    // Reference: bytes land at 0..LENGTH-1; load passes iff the total of all
    // bytes including the checksum is a multiple of 256.
    task automatic load_a(input logic [7:0] d[4], input logic [7:0] chk,
                          input int gap, input int start_at);
        int total = 0;
        bit ok;
        pulse_start(1'b0);
        check("A_ready_after_start", 32'(a_ready), 32'(1));
        for (int i = 0; i < 4; i++) begin
            total += int'(d[i]);
            q_a.push_back({12'(i), d[i]});
            if (i == start_at) a_start = 1'b1;
            send(1'b0, d[i]);
            a_start = 1'b0;
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
        end
        send(1'b0, chk);
        total += int'(chk);
        ok = ((total % 256) == 0);
        check("A_n_booted", 32'(a_nbooted), 32'(!ok));
        check("A_core_rst", 32'(a_corerst), 32'(!ok));
        check("A_load_err", 32'(a_err), 32'(!ok));
        check("A_ready_end", 32'(a_ready), 32'(0));
        check("A_nwe_end", 32'(a_nwe), 32'(1));
        check("A_writes_done", 32'(q_a.size()), 32'(0));
    endtask

    task automatic load_b(input logic [7:0] d, input logic [7:0] chk);
        int total;
        bit ok;
        pulse_start(1'b1);
        q_b.push_back({12'd0, d});
        send(1'b1, d);
        send(1'b1, chk);
        total = int'(d) + int'(chk);
        ok = ((total % 256) == 0);
        check("B_n_booted", 32'(b_nbooted), 32'(!ok));
        check("B_core_rst", 32'(b_corerst), 32'(!ok));
        check("B_load_err", 32'(b_err), 32'(!ok));
        check("B_writes_done", 32'(q_b.size()), 32'(0));
    endtask

    function automatic logic [7:0] good_chk(input logic [7:0] d[4]);
        int total = 0;
        for (int i = 0; i < 4; i++) total += int'(d[i]);
        return 8'((256 - (total % 256)) % 256);
    endfunction

    // ---------------- main sequence
    initial begin
        logic [7:0] d[4];
        logic [7:0] chk;
        int n;
        rst = 1'b0;
        a_start = 0; a_valid = 0; a_data = 0;
        b_start = 0; b_valid = 0; b_data = 0;
        #2;
        do_reset();

        // Reset values
        check("RST_ready", 32'(a_ready), 32'(0));
        check("RST_addr", 32'(a_addr), 32'(0));
        check("RST_data", 32'(a_bdata), 32'(0));
        check("RST_nwe", 32'(a_nwe), 32'(1));
        check("RST_nbooted", 32'(a_nbooted), 32'(1));
        check("RST_corerst", 32'(a_corerst), 32'(1));
        check("RST_err", 32'(a_err), 32'(0));

        // Directed good load, then START ignored in DONE
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_a(d, 8'hF6, 0, -1);
        a_start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        a_start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("DONE_keep_booted", 32'(a_nbooted), 32'(0));
        check("DONE_ready", 32'(a_ready), 32'(0));

        // Bad checksum -> ERROR, then retry from ERROR
        do_reset();
        load_a(d, 8'hF5, 0, -1);
        load_a(d, 8'hF6, 0, -1);

        // Valid gaps plus START held mid-load
        do_reset();
        load_a(d, 8'hF6, 5, 2);

        // Reset during STROBE of the second byte
        do_reset();
        pulse_start(1'b0);
        q_a.push_back({12'd0, 8'h11});
        send(1'b0, 8'h11);
        q_a.push_back({12'd1, 8'h22});
        send(1'b0, 8'h22);
        n = 0;
        do begin @(negedge clk); n++; end while (a_nwe && n < 50);
        check("MID_strobe_addr", 32'(a_addr), 32'(1));
        #1 rst = 1'b1;
        #1;
        check("MID_nwe", 32'(a_nwe), 32'(1));
        check("MID_addr", 32'(a_addr), 32'(0));
        check("MID_data", 32'(a_bdata), 32'(0));
        check("MID_ready", 32'(a_ready), 32'(0));
        check("MID_nbooted", 32'(a_nbooted), 32'(1));
        check("MID_corerst", 32'(a_corerst), 32'(1));
        check("MID_queue", 32'(q_a.size()), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        d = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        load_a(d, good_chk(d), 0, -1);

        // Randomized loads, about half with a corrupted checksum
        for (int k = 0; k < 6; k++) begin
            do_reset();
            d = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            chk = good_chk(d);
            if ($urandom_range(0, 1) == 1) begin
                load_a(d, chk + 8'($urandom_range(1, 255)), $urandom_range(0, 3), -1);
                load_a(d, chk, $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                load_a(d, chk, $urandom_range(0, 3), -1);
            end
        end

        // LENGTH=1 boundary
        do_reset();
        load_b(8'hAA, 8'h56);
        do_reset();
        chk = 8'($urandom);
        load_b(chk, 8'(8'd0 - chk) + 8'($urandom_range(1, 255)));
        check("B_addr_held", 32'(b_addr), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_microcode_loader
`default_nettype wire

// File: doc/microcode_loader.md
Name: microcode_loader

Overview:
- Sequences the bootstrap write port of the microcode SRAM.
- Accepts a byte stream over a valid/ready handshake and issues timed write strobes at consecutive byte addresses.
- Verifies a trailing two's-complement checksum, then deasserts N_BOOTED, which hands the SRAM to the control logic for reads.
- Holds the rest of the core in reset until the load completes successfully.

Parameters:
- ADDR_WIDTH, 12, width of BOOTSTRAP_ADDR.
- LENGTH, 4096, number of microcode bytes to load. Range 1..2**ADDR_WIDTH.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous reset, active-high.
- START  input  1  begins a load from IDLE or ERROR; ignored in every other state.
- IN_DATA  input  8  stream byte.
- IN_VALID  input  1  IN_DATA is valid.
- IN_READY  output  1  loader can accept a byte this cycle.
- BOOTSTRAP_ADDR  output  ADDR_WIDTH  SRAM byte address.
- BOOTSTRAP_DATA  output  8  SRAM write data.
- BOOTSTRAP_N_WE  output  1  SRAM write strobe, active-low.
- N_BOOTED  output  1  high until a verified load completes, then low.
- CORE_RST  output  1  active-high reset to the sequencer and micro-op counter.
- LOAD_ERR  output  1  checksum mismatch detected.

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE
  - IN_READY=0, BOOTSTRAP_ADDR=0, BOOTSTRAP_DATA=0
  - BOOTSTRAP_N_WE=1, N_BOOTED=1, CORE_RST=1, LOAD_ERR=0
  - checksum accumulator=0
- States: IDLE, WAIT_BYTE, SETUP, STROBE, RECOVER, CHECK, DONE, ERROR.
- IDLE/ERROR + START:
  - go to WAIT_BYTE
  - addr=0, sum=0, LOAD_ERR=0
- WAIT_BYTE:
  - IN_READY=1.
  - On IN_VALID&&IN_READY: latch IN_DATA into BOOTSTRAP_DATA, sum+=IN_DATA (mod 256), go to SETUP.
  - With IN_VALID=0, stay indefinitely.
- SETUP (1 cycle):
  - addr and data stable, N_WE=1, IN_READY=0.
  - Go to STROBE.
- STROBE (1 cycle): N_WE=0, go to RECOVER.
- RECOVER (1 cycle):
  - N_WE=1; addr and data are still held, giving SRAM data hold time.
  - If addr==LENGTH-1: go to CHECK and leave addr unchanged.
  - Otherwise: addr+=1, go to WAIT_BYTE.
- Throughput: one byte per 4 cycles when IN_VALID is held high. The byte accepted at edge t has N_WE low during cycle t+2.
- CHECK:
  - IN_READY=1.
  - On handshake, compute (sum+IN_DATA)[7:0]:
    - ==0: go to DONE.
    - otherwise: go to ERROR, LOAD_ERR=1.
  - The checksum byte is never written to the SRAM.
- DONE (terminal until RST):
  - N_BOOTED=0, CORE_RST=0, IN_READY=0, N_WE=1.
- ERROR:
  - N_BOOTED=1, CORE_RST=1, LOAD_ERR stays 1.
  - START retries the full load.
- Invariants:
  - N_WE is never low in any state other than STROBE.
  - N_WE is never low when N_BOOTED=0.
  - BOOTSTRAP_ADDR and BOOTSTRAP_DATA never change in the cycle where N_WE falls or rises.
  - BOOTSTRAP_ADDR never exceeds LENGTH-1; no wrap-around is possible.
- START while loading or in DONE: ignored.
- IN_VALID outside WAIT_BYTE/CHECK: not accepted; the source must hold the byte.
- RST mid-load (including during STROBE): N_WE goes high asynchronously, then reset values apply. A partially loaded SRAM is never marked booted.
- LENGTH=1: the first RECOVER goes directly to CHECK.

Decomposition:
- Shared package:
  - loader state enum
  - CHECKSUM_WIDTH=8
  - stream handshake constants for reuse by the future serial/ROM byte sources
- Sub-module: one natural sub-module, write_strober. It owns SETUP/STROBE/RECOVER timing, the addr/data hold registers and N_WE, with a start/done handshake to the top-level FSM.
- Formal properties (under FORMAL):
  - N_WE low implies state==STROBE.
  - N_BOOTED=0 implies N_WE=1.
  - Address stability around N_WE edges.

Test Plan:
- LENGTH=4, START, stream 01 02 03 04 F6 with IN_VALID held -> writes addr0..3 = 01,02,03,04, each N_WE low exactly 1 cycle; N_BOOTED=0, CORE_RST=0, LOAD_ERR=0 after CHECK.
- Same stream with checksum F5 -> ERROR, LOAD_ERR=1, N_BOOTED=1, CORE_RST=1; a retry with START then the correct stream reaches DONE.
- IN_VALID gaps (deassert 5 cycles between bytes) -> loader waits in WAIT_BYTE, no extra N_WE pulses, final SRAM contents identical.
- RST asserted during STROBE of byte 2 -> N_WE=1 immediately, all outputs at reset values; a subsequent full load succeeds from addr 0.
- START pulsed mid-load and in DONE -> no effect; addresses continue monotonically; DONE remains with no N_WE activity.
- LENGTH=1, stream AA 56 -> single write at addr 0 = AA, DONE.
